cp0_regfile: RTL and testbench

//   Parametrised CP0 system-control register file with exception/ERET

---
 rtl/cp0_regfile.sv | 253 +++++++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 system-control register file.
//
// Holds the MIPS-style CP0 registers that sit beside the MEM/WB boundary.
// It takes MTC0 writes, exception commits and ERET commits from the pipeline.
// It runs a divided Count/Compare timer and drives a masked interrupt request.
//
// Optional feature: define CP0_RANDOM_EN to build the Random register (reg 1).
// When CP0_RANDOM_EN is undefined, reg 1 reads 0.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   hw_int            level-sensitive hardware interrupts, sampled into Cause.IP[15:10]
//   we/waddr/wdata    MTC0 write
//   raddr/rdata       MFC0 read (combinational, from registered state)
//   exc_*             exception commit (one-cycle pulse) with its EPC/BD/BadVAddr data
//   eret              ERET commit (one-cycle pulse)
//   epc_out, status_out, cause_out   current register contents
//   timer_int         Cause.TI
//   int_req           unmasked interrupt pending
module cp0_regfile #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HW_INT_NUM  = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VAL    = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VAL  = 32'h8000_8000,
  parameter int unsigned TLB_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [4:0]            raddr,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [WIDTH-1:0]      exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_badv_we,
  input  logic [WIDTH-1:0]      exc_badvaddr,
  input  logic                  eret,
  output logic [WIDTH-1:0]      epc_out,
  output logic [WIDTH-1:0]      status_out,
  output logic [WIDTH-1:0]      cause_out,
  output logic                  timer_int,
  output logic                  int_req
);

  localparam int unsigned PhaseW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(COUNT_DIV - 1);

  // Architectural state
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  compare_q, compare_d;
  logic [WIDTH-1:0]  epc_q, epc_d;
  logic [WIDTH-1:0]  badv_q, badv_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [7:0]        im_q, im_d;
  logic              exl_q, exl_d;
  logic              ie_q, ie_d;
  logic              bd_q, bd_d;
  logic              ti_q, ti_d;
  logic [1:0]        ip_sw_q, ip_sw_d;
  logic [5:0]        ip_hw_q, ip_hw_d;
  logic [4:0]        exc_code_q, exc_code_d;

  logic [WIDTH-1:0]  status_val;
  logic [WIDTH-1:0]  cause_val;
  logic [WIDTH-1:0]  random_val;
  logic [WIDTH-1:0]  count_inc;
  logic              tick;
  logic              wr_en;
  logic              wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  // MTC0 loses to an exception or ERET committing in the same cycle.
  assign wr_en      = we & ~exc_valid & ~eret;
  assign wr_count   = wr_en && (waddr == 5'd9);
  assign wr_compare = wr_en && (waddr == 5'd11);
  assign wr_status  = wr_en && (waddr == 5'd12);
  assign wr_cause   = wr_en && (waddr == 5'd13);
  assign wr_epc     = wr_en && (waddr == 5'd14);

  assign tick      = (phase_q == PhaseLast);
  assign count_inc = count_q + WIDTH'(1);

  // Timer: divider, Count, Compare, TI
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count) begin
      // A loaded Count restarts the divider and never raises TI.
      count_d = wdata;
      phase_d = '0;
    end else if (tick) begin
      phase_d = '0;
      count_d = count_inc;
      if (count_inc == compare_q) begin
        ti_d = 1'b1;
      end
    end else begin
      phase_d = phase_q + PhaseW'(1);
    end
    // Writing Compare acknowledges the timer interrupt.
    if (wr_compare) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  // Status, Cause, EPC, BadVAddr
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badv_d     = badv_q;
    ip_hw_d    = '0;
    for (int unsigned i = 0; i < HW_INT_NUM; i++) begin
      ip_hw_d[i] = hw_int[i];
    end

    if (exc_valid) begin
      // A nested exception keeps the original EPC/BD.
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
        bd_d  = exc_bd;
      end
      exc_code_d = exc_code;
      exl_d      = 1'b1;
      if (exc_badv_we) begin
        badv_d = exc_badvaddr;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else begin
      if (wr_status) begin
        im_d  = wdata[15:8];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (wr_cause) begin
        ip_sw_d = wdata[9:8];
      end
      if (wr_epc) begin
        epc_d = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      badv_q     <= '0;
      phase_q    <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      badv_q     <= badv_d;
      phase_q    <= phase_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exc_code_q <= exc_code_d;
    end
  end

`ifdef CP0_RANDOM_EN
  localparam int unsigned RandW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [RandW-1:0] RandTop = RandW'(TLB_ENTRIES - 1);

  logic [RandW-1:0] random_q, random_d;

  assign random_d = (random_q == '0) ? RandTop : (random_q - RandW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      random_q <= RandTop;
    end else begin
      random_q <= random_d;
    end
  end

  assign random_val = WIDTH'(random_q);
`else
  // Keeps TLB_ENTRIES referenced when no Random counter is built.
  logic unused_tlb;
  assign unused_tlb = (TLB_ENTRIES == 0);
  assign random_val = '0;
`endif

  // Register views. BEV (bit 22) is hard-wired to 1.
  always_comb begin
    status_val       = '0;
    status_val[22]   = 1'b1;
    status_val[15:8] = im_q;
    status_val[1]    = exl_q;
    status_val[0]    = ie_q;
  end

  // IP[15] carries the timer request ORed onto hardware line 5.
  always_comb begin
    cause_val        = '0;
    cause_val[31]    = bd_q;
    cause_val[30]    = ti_q;
    cause_val[15:10] = {ip_hw_q[5] | ti_q, ip_hw_q[4:0]};
    cause_val[9:8]   = ip_sw_q;
    cause_val[6:2]   = exc_code_q;
  end

  always_comb begin
    rdata = '0;
    unique case (raddr)
      5'd1:    rdata = random_val;
      5'd8:    rdata = badv_q;
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
      5'd12:   rdata = status_val;
      5'd13:   rdata = cause_val;
      5'd14:   rdata = epc_q;
      5'd15:   rdata = WIDTH'(PRID_VAL);
      5'd16:   rdata = WIDTH'(CONFIG_VAL);
      default: rdata = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign status_out = status_val;
  assign cause_out  = cause_val;
  assign timer_int  = ti_q;
  assign int_req    = ie_q & ~exl_q & (|(im_q & cause_val[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: self-checking bench for cp0_regfile.
// Directed sequences, a table of MTC0/MFC0 vectors, then randomized traffic
// checked every cycle against a behavioural model of the register file.
module tb_cp0_regfile;

  localparam int unsigned Div = 2;
  localparam int unsigned Tlb = 16;

  logic        clk;
  logic        rst;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badv_we;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic        timer_int;
  logic        int_req;

  cp0_regfile #(
    .WIDTH       (32),
    .HW_INT_NUM  (6),
    .COUNT_DIV   (Div),
    .PRID_VAL    (32'h0000_4220),
    .CONFIG_VAL  (32'h8000_8000),
    .TLB_ENTRIES (Tlb)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hw_int       (hw_int),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badv_we  (exc_badv_we),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .epc_out      (epc_out),
    .status_out   (status_out),
    .cause_out    (cause_out),
    .timer_int    (timer_int),
    .int_req      (int_req)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Behavioural model: plain variables per architectural field.
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;
  int          m_elapsed;   // cycles since reset or last Count load
  int          m_since_rst; // cycles since reset

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    logic [5:0]  ip;
    ip = m_hw | {m_ti, 5'b0};
    c = ({31'b0, m_bd} << 31) | ({31'b0, m_ti} << 30) | ({26'b0, ip} << 10)
        | ({30'b0, m_sw} << 8) | ({27'b0, m_code} << 2);
    return c;
  endfunction

  function automatic logic m_int_req();
    logic [31:0] c;
    c = m_cause();
    return m_ie && !m_exl && ((m_im & c[15:8]) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_RANDOM_EN
      5'd1:    return 32'(Tlb - 1 - (m_since_rst % Tlb));
`endif
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h8000_8000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    logic        wr;
    logic [31:0] old_cmp;
    if (!rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0;
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
      m_sw = 0; m_hw = 0; m_code = 0;
      m_elapsed = 0; m_since_rst = 0;
    end else begin
      m_since_rst++;
      wr = we && !exc_valid && !eret;
      old_cmp = m_compare;
      if (wr && waddr == 5'd9) begin
        m_count = wdata;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed % Div == 0) begin
          m_count = m_count + 1;
          if (m_count == old_cmp) m_ti = 1'b1;
        end
      end
      if (exc_valid) begin
        if (!m_exl) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd = exc_bd;
        end
        m_code = exc_code;
        m_exl = 1'b1;
        if (exc_badv_we) m_badv = exc_badvaddr;
      end else if (eret) begin
        m_exl = 1'b0;
      end else if (wr) begin
        case (waddr)
          5'd11: begin m_compare = wdata; m_ti = 1'b0; end
          5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
          5'd13: m_sw = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      m_hw = hw_int;
    end
  endtask

  // One clock: compare outputs with the model, take the edge, update the model.
  // Entered and left at the falling edge.
  task automatic cycle();
    #1;
    chk("rdata", rdata, m_read(raddr));
    chk("status_out", status_out, m_status());
    chk("cause_out", cause_out, m_cause());
    chk("epc_out", epc_out, m_epc);
    chk("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
    chk("int_req", {31'b0, int_req}, {31'b0, m_int_req()});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badv_we = 0; exc_badvaddr = 0; eret = 0; hw_int = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    raddr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    cycle();
    we = 0;
  endtask

  task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                     input logic badv_we, input logic [31:0] badv);
    exc_valid = 1; exc_pc = pc; exc_bd = bd; exc_code = code;
    exc_badv_we = badv_we; exc_badvaddr = badv;
    cycle();
    exc_valid = 0; exc_badv_we = 0;
  endtask

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
    vecs[1]  = '{5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
    vecs[2]  = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
    vecs[3]  = '{5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
    vecs[4]  = '{5'd11, 32'h1234_5678, 5'd11, 32'h1234_5678};
    vecs[5]  = '{5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100};
    vecs[6]  = '{5'd8,  32'h0000_AAAA, 5'd8,  32'h0000_0000};
    vecs[7]  = '{5'd15, 32'hFFFF_FFFF, 5'd15, 32'h0000_4220};
    vecs[8]  = '{5'd16, 32'h0000_0000, 5'd16, 32'h8000_8000};
    vecs[9]  = '{5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
    vecs[10] = '{5'd31, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[11] = '{5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};

    idle();
    rst = 0;
    raddr = 5'd9;
    @(negedge clk);
    repeat (3) cycle();

    // Reset state
    chk("rst_status", status_out, 32'h0040_0000);
    chk("rst_cause", cause_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_ti", {31'b0, timer_int}, 32'h0);
    chk("rst_intreq", {31'b0, int_req}, 32'h0);
    rd(5'd9, 32'h0, "rst_count");
    rd(5'd8, 32'h0, "rst_badv");

    // Count divided by 2
    rst = 1;
    repeat (10) cycle();
    rd(5'd9, 32'd5, "count_after10");
    chk("idle_intreq", {31'b0, int_req}, 32'h0);

    // Compare match raises TI and, with IE/IM7, int_req
    mtc0(5'd11, 32'd8);
    mtc0(5'd12, 32'h0040_8001);
    raddr = 5'd9;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rdata == 32'd8) break;
      cycle();
    end
    rd(5'd9, 32'd8, "count_reach8");
    chk("ti_set", {31'b0, timer_int}, 32'h1);
    chk("ip15_set", {31'b0, cause_out[15]}, 32'h1);
    chk("intreq_set", {31'b0, int_req}, 32'h1);
    mtc0(5'd11, 32'd20);
    chk("ti_clear", {31'b0, timer_int}, 32'h0);

    // Exception in a delay slot
    exc(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h13);
    chk("exc_epc", epc_out, 32'hBFC0_00FC);
    chk("exc_bd", {31'b0, cause_out[31]}, 32'h1);
    chk("exc_code", {27'b0, cause_out[6:2]}, 32'd4);
    chk("exc_exl", {31'b0, status_out[1]}, 32'h1);
    rd(5'd8, 32'h13, "exc_badv");

    // Nested exception keeps EPC
    exc(32'h400, 1'b0, 5'd12, 1'b0, 32'h0);
    chk("nest_epc", epc_out, 32'hBFC0_00FC);
    chk("nest_code", {27'b0, cause_out[6:2]}, 32'd12);
    rd(5'd8, 32'h13, "nest_badv");
    eret = 1;
    cycle();
    eret = 0;
    chk("eret_exl", {31'b0, status_out[1]}, 32'h0);
    chk("eret_epc", epc_out, 32'hBFC0_00FC);

    // Exception beats a same-cycle Status write
    we = 1; waddr = 5'd12; wdata = 32'h0;
    exc(32'h800, 1'b0, 5'd1, 1'b0, 32'h0);
    we = 0;
    chk("prio_status", status_out, 32'h0040_8003);
    chk("prio_epc", epc_out, 32'h800);

    // Reset mid-count
    rst = 0;
    cycle();
    chk("mrst_status", status_out, 32'h0040_0000);
    chk("mrst_cause", cause_out, 32'h0);
    chk("mrst_epc", epc_out, 32'h0);
    rd(5'd9, 32'h0, "mrst_count");
    rd(5'd11, 32'h0, "mrst_compare");
    rd(5'd8, 32'h0, "mrst_badv");

`ifdef CP0_RANDOM_EN
    rd(5'd1, 32'd15, "random_0");
    rst = 1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      rd(5'd1, 32'((31 - i) % 16), $sformatf("random_%0d", i));
    end
`else
    rst = 1;
    cycle();
    rd(5'd1, 32'h0, "reg1_zero");
`endif

    // Table of MTC0 write / MFC0 readback pairs
    for (int i = 0; i < 12; i++) begin
      raddr = vecs[i].raddr;
      mtc0(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] addrs [10];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd8, 5'd1, 5'd15, 5'd16, 5'd3};
      rst = ($urandom_range(0, 499) != 0);
      we = ($urandom_range(0, 2) == 0);
      waddr = addrs[$urandom_range(0, 9)];
      wdata = $urandom;
      if (waddr == 5'd11) wdata = m_count + 32'($urandom_range(0, 8));
      raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                          : addrs[$urandom_range(0, 9)];
      exc_valid = ($urandom_range(0, 11) == 0);
      eret = ($urandom_range(0, 11) == 0);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      exc_bd = 1'($urandom);
      exc_badv_we = 1'($urandom);
      exc_badvaddr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
